// File: rtl/fetch_stage.sv
// Purpose : IF stage plus IF/ID pipeline register; owns PCF and the imem request/response handshake.
// Latency : an instruction reaches decode one cycle after its imem response; 1 instr/cycle with 1-cycle imem.
// Backpr. : at most one outstanding request; a response that decode cannot take waits in a 1-entry hold buffer.
//
// Ports:
//   clk, reset                     core clock, synchronous active-high reset
//   StallF, StallD, FlushD         hazard-unit controls (freeze PCF / hold IF/ID / bubble IF/ID)
//   PCSrcE, PCTargetE              redirect from EX (target low two bits ignored)
//   imem_req_valid/ready/addr      instruction memory request channel
//   imem_rsp_valid/data            in-order instruction memory response
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register contents presented to decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // REQ: nothing outstanding; WAIT: one request outstanding;
    // DROP: outstanding request belongs to a squashed path, discard its response.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic ifid_load;
    logic rsp_in_wait;
    logic direct_rsp;
    logic issue_ok;
    logic req_hs;

    // Only the word-aligned part of the redirect target is used.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^PCTargetE[1:0];

    always_comb begin
        ifid_load   = !FlushD && !StallD;
        rsp_in_wait = (state_q == S_WAIT) && imem_rsp_valid && !PCSrcE;
        // Response bypasses the hold buffer only when decode takes it this cycle.
        direct_rsp  = rsp_in_wait && ifid_load && !hold_v_q;
        issue_ok    = !StallF && !PCSrcE && !hold_v_q;
        // A new request may overlap the response that retires the current one,
        // which keeps one instruction per cycle with a single-cycle memory.
        imem_req_valid = !reset && issue_ok && ((state_q == S_REQ) || direct_rsp);
        imem_req_addr  = pcf_q;
        req_hs         = imem_req_valid && imem_req_ready;

        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = {PCTargetE[31:2], 2'b00};
        end else if (req_hs) begin
            pcf_d = pcf_q + 32'd4;
        end

        req_pc_d = req_hs ? pcf_q : req_pc_q;

        state_d = state_q;
        case (state_q)
            S_REQ: begin
                state_d = req_hs ? S_WAIT : S_REQ;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = req_hs ? S_WAIT : S_REQ;
                end else if (PCSrcE) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        hold_v_d     = hold_v_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (hold_v_q && ifid_load) begin
            hold_v_d = 1'b0;
        end
        if (rsp_in_wait && !direct_rsp) begin
            hold_v_d     = 1'b1;
            hold_instr_d = imem_rsp_data;
            hold_pc_d    = req_pc_q;
        end
        if (PCSrcE) begin
            hold_v_d = 1'b0;
        end

        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (FlushD || (!StallD && !hold_v_q && !direct_rsp)) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
        end else if (!StallD && hold_v_q) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = hold_instr_q;
            ifid_pc_d    = hold_pc_q;
            ifid_pc4_d   = hold_pc_q + 32'd4;
        end else if (!StallD && direct_rsp) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rsp_data;
            ifid_pc_d    = req_pc_q;
            ifid_pc4_d   = req_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            req_pc_q     <= 32'd0;
            hold_v_q     <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            req_pc_q     <= req_pc_d;
            hold_v_q     <= hold_v_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign ValidD   = ifid_valid_q;
    assign InstrD   = ifid_instr_q;
    assign PCD      = ifid_pc_q;
    assign PCPlus4D = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : self-checking bench for fetch_stage with a behavioural in-order imem.
// Latency : imem answers one cycle after accept when auto_rsp=1, otherwise on demand.
// Backpr. : imem always ready; stalls/flushes/redirects driven from the stimulus.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] pc_target_e;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (stall_f),
        .StallD         (stall_d),
        .FlushD         (flush_d),
        .PCSrcE         (pcsrc_e),
        .PCTargetE      (pc_target_e),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (instr_d),
        .PCD            (pc_d),
        .PCPlus4D       (pc_plus4_d),
        .ValidD         (valid_d)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } sb_t;

    typedef struct {
        logic        sf;
        logic        sd;
        logic        fd;
        logic        exp_req;
        logic        exp_vld;
        logic [31:0] exp_pcd;
    } vec_t;

    sb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic        auto_rsp;
    logic        pend;
    logic [31:0] pend_addr;
    logic        last_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic present();
        if (pend) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
        end
    endtask

    // One clock: sample before the edge, advance, run the imem model, check IF/ID.
    task automatic tick();
        logic        hs, rsp_now, ld, rst_s, redir, fl;
        logic [31:0] a, tgt;
        sb_t         e;
        @(negedge clk);
        last_req = imem_req_valid;
        hs       = imem_req_valid && imem_req_ready;
        a        = imem_req_addr;
        rsp_now  = imem_rsp_valid;
        rst_s    = reset;
        fl       = flush_d;
        ld       = !reset && !flush_d && !stall_d;
        redir    = pcsrc_e;
        tgt      = {pc_target_e[31:2], 2'b00};
        if (hs) begin
            chk("req_addr", a, exp_pc);
            sb.push_back('{mem_word(a), a, a + 32'd4});
            exp_pc = a + 32'd4;
        end
        @(posedge clk);
        #1;
        if (rst_s) begin
            pend = 1'b0;
            imem_rsp_valid = 1'b0;
            sb.delete();
            exp_pc = 32'h0;
            chk("rst_validd", {31'd0, valid_d}, 32'd0);
            chk("rst_instrd", instr_d, NOP);
            chk("rst_pcd", pc_d, 32'd0);
            chk("rst_pc4d", pc_plus4_d, 32'd0);
        end else begin
            if (rsp_now) begin
                imem_rsp_valid = 1'b0;
                pend = 1'b0;
            end
            if (hs) begin
                pend = 1'b1;
                pend_addr = a;
            end
            if (auto_rsp) present();
            if (ld && valid_d) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", {31'd0, valid_d}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", instr_d, e.instr);
                    chk("sb_pcd", pc_d, e.pc);
                    chk("sb_pc4d", pc_plus4_d, e.pc4);
                end
            end else if (ld || fl) begin
                chk("bubble_valid", {31'd0, valid_d}, 32'd0);
                chk("bubble_instr", instr_d, NOP);
                chk("bubble_pcd", pc_d, 32'd0);
                chk("bubble_pc4d", pc_plus4_d, 32'd0);
            end
            if (redir) begin
                sb.delete();
                exp_pc = tgt;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    vec_t tbl[15];

    initial begin
        // stall_f stall_d flush_d | req before edge, ValidD/PCD after edge
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h08};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0C};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h14};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h18};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1C};

        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; pc_target_e = 32'h0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        auto_rsp = 1'b1; pend = 1'b0; pend_addr = 32'h0; exp_pc = 32'h0; last_req = 1'b0;

        // Reset for two cycles: no request, bubble in IF/ID.
        tick(); chk("rst_req0", {31'd0, last_req}, 32'd0);
        tick(); chk("rst_req1", {31'd0, last_req}, 32'd0);
        reset = 1'b0;

        // Streaming, stall/hold, flush into hold, StallF with an outstanding request.
        for (int i = 0; i < 15; i++) begin
            stall_f = tbl[i].sf; stall_d = tbl[i].sd; flush_d = tbl[i].fd;
            tick();
            chk($sformatf("tbl%0d_req", i), {31'd0, last_req}, {31'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_vld", i), {31'd0, valid_d}, {31'd0, tbl[i].exp_vld});
            chk($sformatf("tbl%0d_pcd", i), pc_d, tbl[i].exp_pcd);
        end
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;

        // Redirect while a slow response is outstanding: late response must be dropped.
        reset = 1'b1; tick(); reset = 1'b0;
        auto_rsp = 1'b0;
        tick(); chk("r4_req0", {31'd0, last_req}, 32'd1);
        pcsrc_e = 1'b1; pc_target_e = 32'h0000_0103;
        tick(); chk("r4_redir_noreq", {31'd0, last_req}, 32'd0);
        pcsrc_e = 1'b0;
        tick(); chk("r4_drop_noreq", {31'd0, last_req}, 32'd0);
        present();
        tick(); chk("r4_late_noreq", {31'd0, last_req}, 32'd0);
        chk("r4_late_vld", {31'd0, valid_d}, 32'd0);
        auto_rsp = 1'b1;
        tick(); chk("r4_req_tgt", {31'd0, last_req}, 32'd1);
        chk("r4_vld_wait", {31'd0, valid_d}, 32'd0);
        tick(); chk("r4_pcd_tgt", pc_d, 32'h0000_0100);
        chk("r4_vld_tgt", {31'd0, valid_d}, 32'd1);

        // Redirect coinciding with a response: response discarded, next fetch from target.
        pcsrc_e = 1'b1; pc_target_e = 32'h0000_0200;
        tick(); chk("r5a_noreq", {31'd0, last_req}, 32'd0);
        chk("r5a_vld", {31'd0, valid_d}, 32'd0);
        pcsrc_e = 1'b0;
        tick(); chk("r5a_req", {31'd0, last_req}, 32'd1);
        tick(); chk("r5a_pcd", pc_d, 32'h0000_0200);

        // Hold buffer full, then redirect: held word is dropped.
        stall_f = 1'b1; stall_d = 1'b1;
        tick(); chk("r5b_hold_noreq", {31'd0, last_req}, 32'd0);
        chk("r5b_ifid_held", pc_d, 32'h0000_0200);
        pcsrc_e = 1'b1; pc_target_e = 32'h0000_0300;
        tick(); chk("r5b_redir_noreq", {31'd0, last_req}, 32'd0);
        pcsrc_e = 1'b0; stall_f = 1'b0; stall_d = 1'b0;
        tick(); chk("r5b_req", {31'd0, last_req}, 32'd1);
        chk("r5b_vld", {31'd0, valid_d}, 32'd0);
        tick(); chk("r5b_pcd", pc_d, 32'h0000_0300);

        // Reset while WAIT, then PC wrap at the top of the address space.
        reset = 1'b1;
        tick(); chk("r6_rst_noreq", {31'd0, last_req}, 32'd0);
        reset = 1'b0;
        tick(); chk("r6_req_after_rst", {31'd0, last_req}, 32'd1);
        pcsrc_e = 1'b1; pc_target_e = 32'hFFFF_FFFF;
        tick();
        pcsrc_e = 1'b0;
        tick(); chk("r6_req_top", {31'd0, last_req}, 32'd1);
        tick(); chk("r6_pcd_top", pc_d, 32'hFFFF_FFFC);
        chk("r6_pc4_wrap", pc_plus4_d, 32'h0000_0000);
        chk("r6_req_wrap", {31'd0, last_req}, 32'd1);
        tick(); chk("r6_pcd_wrapped", pc_d, 32'h0000_0000);
        chk("r6_vld_wrapped", {31'd0, valid_d}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
